// File: rtl/sram_audio_pkg.sv
// Shared types and constants for the SRAM audio record/playback controller.
// Optional looping playback is enabled in the top by defining SRAM_LOOP_PLAY_EN.
package sram_audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_REC        = 3'd1,
      ST_REC_PAUSE  = 3'd2,
      ST_PLAY       = 3'd3,
      ST_PLAY_PAUSE = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_STOP,
      CMD_PAUSE,
      CMD_REC,
      CMD_PLAY
   } cmd_t;

   // SRAM control pins are active-low; this is their parked level.
   localparam logic PIN_IDLE = 1'b1;

   function automatic cmd_t decode_cmd(input logic stop, input logic pause,
                                       input logic rec, input logic play);
      cmd_t c;
      c = CMD_NONE;
      if (stop)       c = CMD_STOP;
      else if (pause) c = CMD_PAUSE;
      else if (rec)   c = CMD_REC;
      else if (play)  c = CMD_PLAY;
      return c;
   endfunction

endpackage

// File: rtl/sram_phy_if.sv
// Registered async-SRAM pin drivers: one-cycle write/read accesses from
// single-cycle commands, tristate DQ, and read-data capture.
module sram_phy_if
   import sram_audio_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr,
   input  logic              i_rd,
   input  logic              i_clr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ub_n,
   output logic              o_sram_lb_n
);

   logic              dq_oe_q;
   logic [DATA_W-1:0] dq_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_sram_ce_n <= PIN_IDLE;
         o_sram_oe_n <= PIN_IDLE;
         o_sram_we_n <= PIN_IDLE;
         o_sram_ub_n <= PIN_IDLE;
         o_sram_lb_n <= PIN_IDLE;
         o_sram_addr <= '0;
         dq_oe_q     <= 1'b0;
         dq_q        <= '0;
         o_rdata     <= '0;
      end else begin
         o_sram_ce_n <= ~(i_wr | i_rd);
         o_sram_ub_n <= ~(i_wr | i_rd);
         o_sram_lb_n <= ~(i_wr | i_rd);
         o_sram_we_n <= ~i_wr;
         // write wins so DQ is never driven while OE is asserted
         o_sram_oe_n <= ~(i_rd & ~i_wr);
         dq_oe_q     <= i_wr;
         if (i_wr | i_rd) o_sram_addr <= i_addr;
         if (i_wr)        dq_q        <= i_wdata;
         if (!o_sram_oe_n)  o_rdata <= io_sram_dq;
         else if (i_clr)    o_rdata <= '0;
      end
   end

   assign io_sram_dq = dq_oe_q ? dq_q : 'z;

endmodule

// File: rtl/sram_audio_ctrl.sv
// Record/playback controller for a 16-bit async SRAM window.
// Define SRAM_LOOP_PLAY_EN to add i_loop (wrap playback instead of stopping).
module sram_audio_ctrl
   import sram_audio_pkg::*;
#(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 2**20
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start_rec,
   input  logic              i_start_play,
   input  logic              i_pause,
   input  logic              i_stop,
`ifdef SRAM_LOOP_PLAY_EN
   input  logic              i_loop,
`endif
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   input  logic              i_rd_req,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic [2:0]        o_state,
   output logic [ADDR_W:0]   o_len,
   output logic [ADDR_W:0]   o_rd_ptr,
   output logic              o_full,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_sram_addr,
   inout  wire  [DATA_W-1:0] io_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ub_n,
   output logic              o_sram_lb_n
);

   localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(MAX_WORDS);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

   state_t            state_q, state_d;
   cmd_t              cmd;
   logic              wr_busy_q, rd_busy_q, rd_real_q;
   logic              pins_busy, start_ok, rec_go, play_go;
   logic              wr_acc, rd_acc, rd_real;
   logic              len_last, end_hit, loop_en;
   logic [ADDR_W-1:0] acc_addr;

`ifdef SRAM_LOOP_PLAY_EN
   assign loop_en = i_loop;
`else
   assign loop_en = 1'b0;
`endif

   assign cmd       = decode_cmd(i_stop, i_pause, i_start_rec, i_start_play);
   assign pins_busy = wr_busy_q | (rd_busy_q & rd_real_q);
   assign start_ok  = (state_q == ST_IDLE) && !pins_busy;
   assign rec_go    = start_ok && (cmd == CMD_REC);
   assign play_go   = start_ok && (cmd == CMD_PLAY) && (o_len != '0);
   assign len_last  = wr_busy_q && ((o_len + 1'b1) == MAX_LEN);
   assign end_hit   = rd_busy_q && rd_real_q && ((o_rd_ptr + 1'b1) == o_len);
   assign o_state   = state_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      o_wr_ready = (state_q == ST_REC) && !o_full && !pins_busy;
      wr_acc     = o_wr_ready && i_wr_valid;
      rd_acc     = i_rd_req && !rd_busy_q;
      rd_real    = rd_acc && (state_q == ST_PLAY) && !wr_busy_q;
      acc_addr   = BASE + o_len[ADDR_W-1:0];
      if (rd_real) acc_addr = BASE + o_rd_ptr[ADDR_W-1:0];

      unique case (cmd)
         CMD_STOP: state_d = ST_IDLE;
         CMD_PAUSE: begin
            case (state_q)
               ST_REC:        state_d = ST_REC_PAUSE;
               ST_REC_PAUSE:  state_d = ST_REC;
               ST_PLAY:       state_d = ST_PLAY_PAUSE;
               ST_PLAY_PAUSE: state_d = ST_PLAY;
               default:       state_d = state_q;
            endcase
         end
         CMD_REC:  if (rec_go)  state_d = ST_REC;
         CMD_PLAY: if (play_go) state_d = ST_PLAY;
         default:  state_d = state_q;
      endcase

      // an access finishing on this edge may end the session regardless of commands
      if (len_last || (end_hit && !loop_en)) state_d = ST_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_busy_q  <= 1'b0;
         rd_busy_q  <= 1'b0;
         rd_real_q  <= 1'b0;
         o_rd_valid <= 1'b0;
         o_done     <= 1'b0;
         o_full     <= 1'b0;
         o_len      <= '0;
         o_rd_ptr   <= '0;
      end else begin
         wr_busy_q  <= wr_acc;
         rd_busy_q  <= rd_acc;
         rd_real_q  <= rd_real;
         o_rd_valid <= rd_busy_q;
         o_done     <= end_hit;
         if (wr_busy_q) o_len  <= o_len + 1'b1;
         if (len_last)  o_full <= 1'b1;
         if (rd_busy_q && rd_real_q)
            o_rd_ptr <= (end_hit && loop_en) ? '0 : o_rd_ptr + 1'b1;
         if (rec_go) begin
            o_len    <= '0;
            o_full   <= 1'b0;
            o_rd_ptr <= '0;
         end
         if (play_go) o_rd_ptr <= '0;
      end
   end

   sram_phy_if #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_phy (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr        (wr_acc),
      .i_rd        (rd_real),
      .i_clr       (rd_busy_q & ~rd_real_q),
      .i_addr      (acc_addr),
      .i_wdata     (i_wr_data),
      .o_rdata     (o_rd_data),
      .o_sram_addr (o_sram_addr),
      .io_sram_dq  (io_sram_dq),
      .o_sram_ce_n (o_sram_ce_n),
      .o_sram_oe_n (o_sram_oe_n),
      .o_sram_we_n (o_sram_we_n),
      .o_sram_ub_n (o_sram_ub_n),
      .o_sram_lb_n (o_sram_lb_n)
   );

endmodule
